// File: rtl/seq_pkg.sv
// Shared sizing helpers and parameter bounds for the seq_detect_fsm slice.
package seq_pkg;

  localparam int PAT_LEN_MIN = 2;
  localparam int PAT_LEN_MAX = 16;
  localparam int CNT_W_MIN   = 1;

  // Width needed to hold a matched-prefix length of 0..pat_len.
  function automatic int sw_calc(input int pat_len);
    return $clog2(pat_len + 1);
  endfunction

  function automatic bit params_ok(input int pat_len, input int cnt_w);
    return (pat_len >= PAT_LEN_MIN) && (pat_len <= PAT_LEN_MAX) && (cnt_w >= CNT_W_MIN);
  endfunction

endpackage

// File: rtl/seq_detect_fsm_seq_next_state.sv
// Combinational KMP next-state function built from PATTERN (MSB received first).
module seq_next_state
  import seq_pkg::*;
#(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
  parameter int                 SW      = sw_calc(PAT_LEN)
) (
  input  logic [SW-1:0] state,
  input  logic          din,
  input  logic          overlap,
  output logic [SW-1:0] next
);

  // Pattern bit i counted in arrival order (i = 0 is received first).
  function automatic logic pat_bit(input int i);
    return PATTERN[PAT_LEN-1-i];
  endfunction

  always_comb begin : p_next
    int   kp;
    int   idx;
    logic ok;
    logic sb;
    next = '0;
    kp   = int'(state);
    idx  = 0;
    ok   = 1'b0;
    sb   = 1'b0;
    if (int'(state) <= PAT_LEN) begin
      if ((int'(state) == PAT_LEN) && !overlap) kp = 0;
      // s = first kp pattern bits followed by din; keep the longest suffix that is a prefix
      for (int j = 1; j <= PAT_LEN; j++) begin
        if (j <= kp + 1) begin
          ok = 1'b1;
          for (int t = 0; t < PAT_LEN; t++) begin
            if (t < j) begin
              idx = kp + 1 - j + t;
              sb  = (idx == kp) ? din : pat_bit(idx);
              if (sb != pat_bit(t)) ok = 1'b0;
            end
          end
          if (ok) next = SW'(j);
        end
      end
    end
  end

endmodule

// File: rtl/seq_detect_fsm.sv
// Pattern-driven Moore sequence detector with overlap select and saturating match counter.
module seq_detect_fsm
  import seq_pkg::*;
#(
  parameter int                 PAT_LEN = 4,
  parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
  parameter int                 CNT_W   = 8,
  parameter int                 SW      = sw_calc(PAT_LEN)
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             en,
  input  logic             din,
  input  logic             overlap,
  input  logic             clr,
  output logic [SW-1:0]    state_reg,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             busy
);

  // state     | meaning
  // S_IDLE    | no pattern prefix matched
  // S_k       | last k bits equal the first k pattern bits (0 < k < PAT_LEN)
  // S_MATCH   | full pattern seen; match asserted
  // > S_MATCH | unreachable; returns to S_IDLE on the next enabled edge
  localparam logic [SW-1:0] S_IDLE  = '0;
  localparam logic [SW-1:0] S_MATCH = SW'(PAT_LEN);

  if (!params_ok(PAT_LEN, CNT_W)) begin : g_bad_params
    $error("seq_detect_fsm: PAT_LEN must be 2..16 and CNT_W at least 1");
  end

  logic [SW-1:0] state_nxt;
  logic          cnt_full;

  seq_next_state #(
    .PAT_LEN (PAT_LEN),
    .PATTERN (PATTERN),
    .SW      (SW)
  ) u_next (
    .state   (state_reg),
    .din     (din),
    .overlap (overlap),
    .next    (state_nxt)
  );

  assign cnt_full = &match_cnt;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_reg <= S_IDLE;
      match_cnt <= '0;
    end else if (clr) begin
      state_reg <= S_IDLE;
      match_cnt <= '0;
    end else if (en) begin
      state_reg <= state_nxt;
      if ((state_nxt == S_MATCH) && !cnt_full) match_cnt <= match_cnt + 1'b1;
    end
  end

  assign match = (state_reg == S_MATCH);
  assign busy  = (state_reg != S_IDLE) && !match;

endmodule

// File: tb/tb_seq_detect_fsm.sv
// Directed bench for seq_detect_fsm: suffix/prefix model plus literal spot checks.
module tb_seq_detect_fsm;

  localparam int               PL  = 4;
  localparam logic [PL-1:0]    PAT = 4'b1011;

  logic clk = 1'b0;
  logic nrst = 1'b0;
  logic en = 1'b0, din = 1'b0, overlap = 1'b0, clr = 1'b0;

  logic [2:0] state8, state2;
  logic       match8, match2, busy8, busy2;
  logic [7:0] cnt8;
  logic [1:0] cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_detect_fsm #(.PAT_LEN(PL), .PATTERN(PAT), .CNT_W(8)) u_dut8 (
    .clk(clk), .nrst(nrst), .en(en), .din(din), .overlap(overlap), .clr(clr),
    .state_reg(state8), .match(match8), .match_cnt(cnt8), .busy(busy8));

  seq_detect_fsm #(.PAT_LEN(PL), .PATTERN(PAT), .CNT_W(2)) u_dut2 (
    .clk(clk), .nrst(nrst), .en(en), .din(din), .overlap(overlap), .clr(clr),
    .state_reg(state2), .match(match2), .match_cnt(cnt2), .busy(busy2));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: remember the recent bit history; state is the longest history suffix that is a pattern prefix.
  int m_hist = 0;
  int m_len = 0;
  int m_state = 0;
  int m_cnt8 = 0;
  int m_cnt2 = 0;

  always @(posedge clk or negedge nrst) begin : p_model
    int h, l, s;
    if (!nrst) begin
      m_hist <= 0; m_len <= 0; m_state <= 0; m_cnt8 <= 0; m_cnt2 <= 0;
    end else if (clr) begin
      m_hist <= 0; m_len <= 0; m_state <= 0; m_cnt8 <= 0; m_cnt2 <= 0;
    end else if (en) begin
      h = m_hist; l = m_len;
      if (m_state == PL && !overlap) begin h = 0; l = 0; end
      h = ((h << 1) | int'(din)) & ((1 << PL) - 1);
      l = (l < PL) ? l + 1 : PL;
      s = 0;
      for (int j = 1; j <= PL; j++)
        if (j <= l && (h & ((1 << j) - 1)) == (int'(PAT) >> (PL - j))) s = j;
      m_hist <= h; m_len <= l; m_state <= s;
      if (s == PL) begin
        m_cnt8 <= (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
        m_cnt2 <= (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
      end
    end
  end

  always @(negedge clk) begin
    if (nrst) begin
      chk("cmp_state8", int'(state8), m_state);
      chk("cmp_state2", int'(state2), m_state);
      chk("cmp_match", int'(match8), int'(m_state == PL));
      chk("cmp_busy", int'(busy8), int'(m_state != 0 && m_state != PL));
      chk("cmp_cnt8", int'(cnt8), m_cnt8);
      chk("cmp_cnt2", int'(cnt2), m_cnt2);
    end
  end

  task automatic step(input logic e, input logic d, input logic c);
    @(negedge clk);
    en = e; din = d; clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [15:0] bits, input int n, input int exp_states[$]);
    for (int i = 0; i < n; i++) begin
      step(1'b1, bits[n-1-i], 1'b0);
      if (i < exp_states.size()) chk($sformatf("state_bit%0d", i), int'(state8), exp_states[i]);
    end
  endtask

  initial begin
    int none[$];
    none = {};
    #12;
    chk("rst_state", int'(state8), 0);
    chk("rst_match", int'(match8), 0);
    chk("rst_busy", int'(busy8), 0);
    chk("rst_cnt", int'(cnt8), 0);
    @(negedge clk);
    nrst = 1'b1;

    // Overlapping stream 1011011
    overlap = 1'b1;
    feed(16'b1011011, 7, '{1, 2, 3, 4, 2, 3, 4});
    chk("ovl_cnt", int'(cnt8), 2);
    chk("ovl_match", int'(match8), 1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk("hold_match", int'(match8), 1);
    chk("hold_cnt", int'(cnt8), 2);
    step(1'b0, 1'b0, 1'b1);
    chk("clr_cnt", int'(cnt8), 0);

    // Non-overlapping stream 1011011
    overlap = 1'b0;
    feed(16'b1011011, 7, '{1, 2, 3, 4, 0, 1, 1});
    chk("novl_cnt", int'(cnt8), 1);
    step(1'b0, 1'b0, 1'b1);

    // Enable hold mid-pattern, then mismatch
    feed(16'b10, 2, '{1, 2});
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0);
      chk("en_hold_state", int'(state8), 2);
      chk("en_hold_busy", int'(busy8), 1);
    end
    feed(16'b0, 1, '{0});
    chk("mismatch_busy", int'(busy8), 0);

    // Saturation on the 2-bit counter: five overlapping matches
    overlap = 1'b1;
    feed(16'b1011, 4, '{1, 2, 3, 4});
    chk("sat_cnt2_1", int'(cnt2), 1);
    for (int m = 2; m <= 5; m++) begin
      feed(16'b011, 3, '{2, 3, 4});
      chk($sformatf("sat_cnt2_%0d", m), int'(cnt2), (m < 3) ? m : 3);
      chk($sformatf("sat_cnt8_%0d", m), int'(cnt8), m);
    end
    feed(16'b01, 2, '{2, 3});
    chk("pre_rst_cnt", int'(cnt8), 5);

    // Asynchronous reset between edges
    #2;
    nrst = 1'b0;
    #1;
    chk("arst_state", int'(state8), 0);
    chk("arst_cnt", int'(cnt8), 0);
    chk("arst_match", int'(match8), 0);
    chk("arst_busy", int'(busy8), 0);
    nrst = 1'b1;
    feed(16'b1011, 4, '{1, 2, 3, 4});
    chk("post_rst_cnt", int'(cnt8), 1);

    // clr on the same edge as the final pattern bit
    step(1'b0, 1'b0, 1'b1);
    feed(16'b101, 3, '{1, 2, 3});
    step(1'b1, 1'b1, 1'b1);
    chk("clr_pri_state", int'(state8), 0);
    chk("clr_pri_cnt", int'(cnt8), 0);
    chk("clr_pri_match", int'(match8), 0);
    step(1'b0, 1'b0, 1'b0);
    chk("clr_pri_match_after", int'(match8), 0);
    feed(16'b0, 0, none);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
